// File: rtl/wishbone_arbiter_if.sv
// Wishbone classic bus bundle shared by the arbiter's requester side and interconnect side.
// The master modport drives a request; the slave modport answers it.
interface wishbone_interface;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_mosi;
  logic [31:0] dat_miso;
  logic        ack;
  logic        err;

  modport master (output cyc, stb, we, adr, sel, dat_mosi, input  ack, err, dat_miso);
  modport slave  (input  cyc, stb, we, adr, sel, dat_mosi, output ack, err, dat_miso);
endinterface

// File: rtl/wishbone_arbiter.sv
// Round-robin N:1 Wishbone arbiter with a registered grant held for a whole cyc tenure.
// Defining WB_ARB_WATCHDOG_EN adds a per-tenure hold watchdog (MAX_HOLD cycles without ack).
module wishbone_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int MAX_HOLD    = 1024
) (
  input  logic                           clk,
  input  logic                           rst_n,
  wishbone_interface.slave               masters [NUM_MASTERS],
  wishbone_interface.master              slave,
  output logic [NUM_MASTERS-1:0]         grant,
  output logic                           grant_valid,
  output logic [$clog2(NUM_MASTERS)-1:0] owner,
  output logic                           wdog_fire
);
  localparam int IW = $clog2(NUM_MASTERS);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          owner_q, owner_d;
  logic [IW-1:0]          last_q, last_d;
  logic [IW-1:0]          pick_s;
  logic                   pick_vld_s;
  logic [NUM_MASTERS-1:0] req_s, elig_s, stb_s, we_s;
  logic                   owner_req_s;
  logic                   expire_s;
  logic [31:0]            adr_s [NUM_MASTERS];
  logic [31:0]            dat_s [NUM_MASTERS];
  logic [3:0]             sel_s [NUM_MASTERS];
  logic                   fwd_cyc_s, fwd_stb_s, fwd_we_s;
  logic [31:0]            fwd_adr_s, fwd_dat_s;
  logic [3:0]             fwd_sel_s;

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_master
    assign req_s[g]  = masters[g].cyc;
    assign stb_s[g]  = masters[g].stb;
    assign we_s[g]   = masters[g].we;
    assign adr_s[g]  = masters[g].adr;
    assign dat_s[g]  = masters[g].dat_mosi;
    assign sel_s[g]  = masters[g].sel;
    // Non-owners see an idle bus; a watchdog expiry errors the owner.
    assign masters[g].ack      = grant_q[g] & slave.ack;
    assign masters[g].err      = grant_q[g] & (slave.err | expire_s);
    assign masters[g].dat_miso = grant_q[g] ? slave.dat_miso : 32'h0000_0000;
  end

`ifdef WB_ARB_WATCHDOG_EN
  localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

  logic [HW-1:0]          hold_q, hold_d;
  logic [NUM_MASTERS-1:0] blk_q, blk_d;

  assign expire_s = (state_q == BUSY) && (hold_q == HW'(MAX_HOLD - 1));
  // A master cut off by the watchdog stays ineligible until it drops cyc.
  assign elig_s   = req_s & ~blk_q;

  // Hold counter and block-mask next state.
  always_comb begin
    hold_d = '0;
    blk_d  = blk_q & req_s;
    if (expire_s) begin
      blk_d = blk_d | grant_q;
    end else begin
      blk_d = blk_d;
    end
    if ((state_q == BUSY) && !slave.ack && !expire_s) begin
      hold_d = hold_q + HW'(1);
    end else begin
      hold_d = '0;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      blk_q  <= '0;
    end else begin
      hold_q <= hold_d;
      blk_q  <= blk_d;
    end
  end
`else
  assign expire_s = 1'b0;
  assign elig_s   = req_s;
`endif

  assign owner_req_s = |(req_s & grant_q);

  // Round-robin pick: lowest distance after last wins; scanning downward lets it overwrite.
  always_comb begin
    int idx;
    idx        = 0;
    pick_s     = '0;
    pick_vld_s = 1'b0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      idx = (int'(last_q) + k) % NUM_MASTERS;
      if (elig_s[IW'(idx)]) begin
        pick_s     = IW'(idx);
        pick_vld_s = 1'b1;
      end else begin
        pick_s     = pick_s;
      end
    end
  end

  // Arbitration FSM next state.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (pick_vld_s) begin
          state_d = BUSY;
          grant_d = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << pick_s;
          owner_d = pick_s;
          last_d  = pick_s;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (!owner_req_s || expire_s) begin
          state_d = IDLE;
          grant_d = '0;
          owner_d = '0;
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        owner_d = '0;
      end
    endcase
  end

  // Arbitration FSM registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // One-hot AND-OR mux of the owner's request onto the interconnect.
  always_comb begin
    fwd_cyc_s = 1'b0;
    fwd_stb_s = 1'b0;
    fwd_we_s  = 1'b0;
    fwd_adr_s = 32'h0000_0000;
    fwd_dat_s = 32'h0000_0000;
    fwd_sel_s = 4'h0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        fwd_cyc_s = fwd_cyc_s | req_s[i];
        fwd_stb_s = fwd_stb_s | stb_s[i];
        fwd_we_s  = fwd_we_s  | we_s[i];
        fwd_adr_s = fwd_adr_s | adr_s[i];
        fwd_dat_s = fwd_dat_s | dat_s[i];
        fwd_sel_s = fwd_sel_s | sel_s[i];
      end else begin
        fwd_cyc_s = fwd_cyc_s;
      end
    end
  end

  assign slave.cyc      = fwd_cyc_s & ~expire_s;
  assign slave.stb      = fwd_stb_s & ~expire_s;
  assign slave.we       = fwd_we_s;
  assign slave.adr      = fwd_adr_s;
  assign slave.dat_mosi = fwd_dat_s;
  assign slave.sel      = fwd_sel_s;

  assign grant       = grant_q;
  assign grant_valid = (state_q == BUSY);
  assign owner       = owner_q;
  assign wdog_fire   = expire_s;
endmodule

// File: doc/wishbone_arbiter.md
Name: wishbone_arbiter

Overview:
- N-master to 1-slave Wishbone arbiter. Shares the single master port of wishbone_interconn between requesters: RISC-V core instruction fetch, core data port, CNN accelerator DMA, secure-boot engine.
- Round-robin grant, held for a whole bus tenure (master cyc high).
- Registered grant. Only the owning master's signals reach the interconnect.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8).
- MAX_HOLD, 1024, watchdog limit in cycles per tenure. Used only when WB_ARB_WATCHDOG_EN is defined.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- masters  wishbone_interface.slave  [NUM_MASTERS]  requester-side buses
- slave  wishbone_interface.master  1  bus to the interconnect master port
- grant  output  NUM_MASTERS  one-hot current owner, registered
- grant_valid  output  1  high while a tenure is active
- owner  output  $clog2(NUM_MASTERS)  index of current owner; 0 when not granted
- wdog_fire  output  1  one-cycle pulse on watchdog expiry; tied 0 without the macro

Behaviour:
- Reset (async assert, sync deassert expected upstream):
  - state=IDLE; grant=0; grant_valid=0; owner=0; last=NUM_MASTERS-1, so master 0 wins first.
  - slave.cyc=0, slave.stb=0. All masters[i].ack/err=0 and dat_miso=0.
  - wdog_fire=0; hold counter=0.
- Request: req[i] = masters[i].cyc.
- States:
  - IDLE: if |req, pick the first i with req[i], scanning from last+1 upward with wrap modulo NUM_MASTERS. Register grant[i], owner=i, grant_valid=1, last=i. Go to BUSY. If no request, stay.
  - BUSY: when masters[owner].cyc=0, clear grant, grant_valid and owner on the next edge, then go to IDLE. Re-arbitration happens in that IDLE cycle.
- Latency and tenure gaps:
  - Request to grant: 1 cycle. Request to slave.cyc: 1 cycle.
  - Between tenures: exactly 1 idle cycle with slave.cyc=0, even if another master is waiting.
- Forwarding, combinational from registered grant:
  - slave.{cyc,stb,adr,sel,we,dat_mosi} = owner's signals when grant_valid, else 0.
  - masters[owner].{ack,err,dat_miso} = slave.{ack,err,dat_miso}.
  - Non-owners get ack=0, err=0, dat_miso=0. A non-owner holding cyc simply waits.
- Stable grant: no preemption in BUSY. Multi-beat bursts (cyc held, stb toggling) stay with one owner.
- Simultaneous events:
  - Owner drops cyc while others request: release takes priority, next grant goes to the round-robin successor of last.
  - A requester that raises and drops cyc while in IDLE is treated as absent.
- Reset mid-tenure: slave.cyc drops immediately (asynchronous). Masters must restart their transfer.
- Fairness: with all NUM_MASTERS requesting continuously, each master is granted once every NUM_MASTERS tenures.

Optional Feature:
- Macro: WB_ARB_WATCHDOG_EN.
- Defined:
  - A hold counter clears on grant and increments each BUSY cycle with slave.ack=0. It clears whenever slave.ack=1.
  - When the counter reaches MAX_HOLD-1: drive masters[owner].err=1 for one cycle and pulse wdog_fire. Force slave.cyc=0 that same cycle, clear grant and go to IDLE. The offending master must drop cyc before it is considered again.
- Undefined: no counter is built, wdog_fire is tied 0, and tenures are unbounded.

Test Plan:
- Reset, then only master 2 raises cyc/stb with adr=0x100 -> grant=4'b0100 one cycle later. slave.adr=0x100. Slave ack with dat_miso=0xDEADBEEF is returned to master 2 only.
- Masters 0-3 all request continuously, each completing single-beat tenures -> grant order 0,1,2,3,0. One cycle with slave.cyc=0 between each tenure.
- Master 1 holds cyc for a 4-beat burst while master 0 requests -> grant stays 4'b0010 for all 4 acks. Master 0 is granted 2 cycles after master 1 drops cyc.
- rst_n asserted mid-burst on master 3 -> same-cycle slave.cyc=0, grant=0, grant_valid=0. After release, master 0 wins first if requesting.
- With WB_ARB_WATCHDOG_EN and MAX_HOLD=16: master 0 holds cyc and the slave never acks -> at tenure cycle 16, masters[0].err=1 and wdog_fire=1 for one cycle, then grant=0.
- Without the macro, same stimulus -> grant held indefinitely, wdog_fire stays 0.
